commu_m_intc: RTL and testbench

COMMU_M_INTC -- requirements
Module: commu_m_intc

---
 rtl/commu_m_intc.sv | 184 ++++++++++++++++++
 tb/tb_commu_m_intc.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/commu_m_intc.sv
// commu_m_intc: interrupt controller that hands buffered package channels to
// an ARM, one channel at a time, in round-robin order.
//
// Handshake: the ARM is signalled by arm_int_n low for exactly the cycles the
// controller spends in S_UP; the ARM acknowledges by producing a rising edge on
// buf_frm[cur_ch]. Edges on other channels are ignored. A missing acknowledge
// is cut short by the watchdog; repeated misses fault the channel until
// clr_err releases it. A low gap of T_DOWN cycles always follows an interrupt.
module commu_m_intc #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 4,
  parameter int T_POR     = 10_000_000,
  parameter int T_WD      = 300_000_000,
  parameter int T_DOWN    = 1_000_000,
  parameter int MAX_RETRY = 3
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic [N_CH*CNT_W-1:0] cnt_pkg_buf,
  input  logic [N_CH-1:0]       buf_frm,
  input  logic [N_CH-1:0]       en_ch,
  input  logic [N_CH-1:0]       clr_err,
  output logic                  arm_int_n,
  output logic [2:0]            cur_ch,
  output logic [7:0]            stu_buf_rdy,
  output logic                  wd_arm_high,
  output logic [N_CH-1:0]       err_ch,
  output logic [2:0]            dbg_state
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int POR_W = $clog2(T_POR + 1);
  localparam int WD_W  = $clog2(T_WD + 1);
  localparam int DN_W  = $clog2(T_DOWN + 1);

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_IDLE = 3'd1,
    S_ARB  = 3'd2,
    S_UP   = 3'd3,
    S_DOWN = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [N_CH-1:0]   buf_frm_q;
  logic [POR_W-1:0]  por_q, por_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [DN_W-1:0]   dn_q, dn_d;
  logic [2:0]        cur_ch_q, cur_ch_d;
  logic [2:0]        last_ch_q, last_ch_d;
  logic              arm_int_n_q, arm_int_n_d;
  logic              wd_pulse_q, wd_pulse_d;
  logic [N_CH-1:0]   err_q, err_d;
  logic [3:0]        retry_q [N_CH];
  logic [3:0]        retry_d [N_CH];

  logic [N_CH-1:0]   rise;
  logic [N_CH-1:0]   elig;
  logic              rise_cur;
  logic              timeout;
  logic              pick_found;
  logic [2:0]        pick_idx;
  int                rr_idx;

  // Acknowledge edge detect and per-channel eligibility.
  always_comb begin
    rise     = buf_frm & ~buf_frm_q;
    rise_cur = rise[cur_ch_q[CH_W-1:0]];
    timeout  = (state_q == S_UP) && (wd_q == WD_W'(T_WD - 1)) && !rise_cur;
    for (int k = 0; k < N_CH; k++) begin
      elig[k] = (cnt_pkg_buf[k*CNT_W +: CNT_W] != '0) && en_ch[k] && !err_q[k];
    end
  end

  // Round-robin pick: first eligible channel after last_ch, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    rr_idx     = 0;
    for (int i = 0; i < N_CH; i++) begin
      rr_idx = (int'(last_ch_q) + 1 + i) % N_CH;
      if (!pick_found && elig[rr_idx]) begin
        pick_found = 1'b1;
        pick_idx   = 3'(rr_idx);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  // FSM next-state logic; the acknowledge takes priority over the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  if (por_q == POR_W'(T_POR - 1)) state_d = S_IDLE;
      S_IDLE: if (|elig) state_d = S_ARB;
      S_ARB:  state_d = pick_found ? S_UP : S_IDLE;
      S_UP:   if (rise_cur || timeout) state_d = S_DOWN;
      S_DOWN: if (dn_q == DN_W'(T_DOWN - 1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_RST;
    endcase
  end

  // FSM outputs and counter next values; counters clear when their state is left.
  always_comb begin
    arm_int_n_d = ~(state_d == S_UP);
    wd_pulse_d  = timeout;
    cur_ch_d    = (state_q == S_ARB && pick_found) ? pick_idx : cur_ch_q;
    last_ch_d   = (state_q == S_DONE) ? cur_ch_q : last_ch_q;
    por_d       = (state_q == S_RST && por_q != POR_W'(T_POR)) ? por_q + 1'b1 : por_q;
    wd_d        = (state_q == S_UP && state_d == S_UP) ? wd_q + 1'b1 : '0;
    dn_d        = (state_q == S_DOWN && state_d == S_DOWN) ? dn_q + 1'b1 : '0;
  end

  // Retry and fault bookkeeping; a fault being set beats a coincident clear.
  always_comb begin
    err_d = err_q;
    for (int k = 0; k < N_CH; k++) begin
      retry_d[k] = retry_q[k];
      if (clr_err[k]) begin
        retry_d[k] = 4'd0;
        err_d[k]   = 1'b0;
      end
      if ((state_q == S_UP) && (CH_W'(k) == cur_ch_q[CH_W-1:0])) begin
        if (rise_cur) begin
          retry_d[k] = 4'd0;
        end else if (timeout) begin
          if (retry_q[k] == 4'(MAX_RETRY - 1)) begin
            err_d[k]   = 1'b1;
            retry_d[k] = 4'd0;
          end else begin
            retry_d[k] = retry_d[k] + 4'd1;
          end
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      buf_frm_q   <= '0;
      por_q       <= '0;
      wd_q        <= '0;
      dn_q        <= '0;
      cur_ch_q    <= 3'd0;
      last_ch_q   <= 3'(N_CH - 1);
      arm_int_n_q <= 1'b1;
      wd_pulse_q  <= 1'b0;
      err_q       <= '0;
      for (int k = 0; k < N_CH; k++) retry_q[k] <= 4'd0;
    end else begin
      buf_frm_q   <= buf_frm;
      por_q       <= por_d;
      wd_q        <= wd_d;
      dn_q        <= dn_d;
      cur_ch_q    <= cur_ch_d;
      last_ch_q   <= last_ch_d;
      arm_int_n_q <= arm_int_n_d;
      wd_pulse_q  <= wd_pulse_d;
      err_q       <= err_d;
      for (int k = 0; k < N_CH; k++) retry_q[k] <= retry_d[k];
    end
  end

  // Status one-hot is only shown while the interrupt is asserted.
  always_comb begin
    stu_buf_rdy = 8'h00;
    if (!arm_int_n_q) stu_buf_rdy[cur_ch_q] = 1'b1;
  end

  assign arm_int_n   = arm_int_n_q;
  assign cur_ch      = cur_ch_q;
  assign wd_arm_high = wd_pulse_q;
  assign err_ch      = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_commu_m_intc.sv
// Directed bench for commu_m_intc with small timing parameters.
module tb_commu_m_intc;

  localparam int N_CH  = 4;
  localparam int CNT_W = 4;

  logic                  clk_sys;
  logic                  rst_n;
  logic [N_CH*CNT_W-1:0] cnt_pkg_buf;
  logic [N_CH-1:0]       buf_frm;
  logic [N_CH-1:0]       en_ch;
  logic [N_CH-1:0]       clr_err;
  logic                  arm_int_n;
  logic [2:0]            cur_ch;
  logic [7:0]            stu_buf_rdy;
  logic                  wd_arm_high;
  logic [N_CH-1:0]       err_ch;
  logic [2:0]            dbg_state;

  int checks   = 0;
  int failures = 0;

  commu_m_intc #(
    .N_CH(N_CH), .CNT_W(CNT_W), .T_POR(16), .T_WD(100), .T_DOWN(8), .MAX_RETRY(2)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .cnt_pkg_buf(cnt_pkg_buf), .buf_frm(buf_frm),
    .en_ch(en_ch), .clr_err(clr_err), .arm_int_n(arm_int_n), .cur_ch(cur_ch),
    .stu_buf_rdy(stu_buf_rdy), .wd_arm_high(wd_arm_high), .err_ch(err_ch),
    .dbg_state(dbg_state)
  );

  // Clock.
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cnt(input int ch, input logic [CNT_W-1:0] val);
    cnt_pkg_buf[ch*CNT_W +: CNT_W] = val;
  endtask

  // Waits (bounded) for arm_int_n to reach lvl; n counts falling clock edges waited.
  task automatic wait_level(input logic lvl, input int bound, output int n, output bit found);
    n = 0;
    found = 1'b0;
    while (n < bound && !found) begin
      if (arm_int_n === lvl) found = 1'b1;
      else begin
        @(negedge clk_sys);
        n++;
      end
    end
    if (!found && arm_int_n === lvl) found = 1'b1;
  endtask

  // ARM acknowledge: one-cycle high on buf_frm[ch].
  task automatic ack(input int ch);
    buf_frm[ch] = 1'b1;
    @(negedge clk_sys);
    buf_frm[ch] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_arm_int_n", 32'(arm_int_n), 32'd1);
    check("rst_cur_ch", 32'(cur_ch), 32'd0);
    check("rst_stu", 32'(stu_buf_rdy), 32'h00);
    check("rst_wd", 32'(wd_arm_high), 32'd0);
    check("rst_err", 32'(err_ch), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int  n;
    bit  found;
    bit  hi_ok;
    bit  wd_seen;
    int  order [4];
    logic [7:0] onehot [4];

    rst_n       = 1'b0;
    cnt_pkg_buf = '0;
    buf_frm     = '0;
    en_ch       = 4'hF;
    clr_err     = '0;

    // Power-on hold-off with ch0 pending from reset.
    set_cnt(0, 4'd1);
    do_reset();
    wait_level(1'b0, 40, n, found);
    check("por_int_found", 32'(found), 32'd1);
    check("por_holdoff_window", 32'(n >= 17 && n <= 19), 32'd1);
    check("por_stu", 32'(stu_buf_rdy), 32'h01);
    check("por_cur_ch", 32'(cur_ch), 32'd0);

    // Edges on a non-served channel are ignored.
    ack(1);
    @(negedge clk_sys);
    check("frm1_ignored_arm", 32'(arm_int_n), 32'd0);
    check("frm1_ignored_cur", 32'(cur_ch), 32'd0);

    // Acknowledge on ch0 releases the interrupt and opens the low gap.
    buf_frm[0] = 1'b1;
    @(negedge clk_sys);
    set_cnt(0, 4'd0);
    wait_level(1'b1, 2, n, found);
    check("ack_release", 32'(found), 32'd1);
    hi_ok = 1'b1;
    wd_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (arm_int_n !== 1'b1) hi_ok = 1'b0;
      if (wd_arm_high !== 1'b0) wd_seen = 1'b1;
      @(negedge clk_sys);
    end
    check("ack_gap_high", 32'(hi_ok), 32'd1);
    check("ack_no_wd", 32'(wd_seen), 32'd0);
    buf_frm[0] = 1'b0;

    // Round-robin from reset: 0, 2, 3, 0.
    order  = '{0, 2, 3, 0};
    onehot = '{8'h01, 8'h04, 8'h08, 8'h01};
    set_cnt(0, 4'd1);
    set_cnt(2, 4'd1);
    set_cnt(3, 4'd1);
    do_reset();
    for (int s = 0; s < 4; s++) begin
      wait_level(1'b0, 60, n, found);
      check($sformatf("rr%0d_found", s), 32'(found), 32'd1);
      check($sformatf("rr%0d_cur_ch", s), 32'(cur_ch), 32'(order[s]));
      check($sformatf("rr%0d_stu", s), 32'(stu_buf_rdy), 32'(onehot[s]));
      ack(order[s]);
      if (s == 3) cnt_pkg_buf = '0;
      wait_level(1'b1, 3, n, found);
      check($sformatf("rr%0d_release", s), 32'(found), 32'd1);
    end

    // Watchdog: ch1 never acknowledged; mid-interrupt input changes do not abort.
    set_cnt(1, 4'd1);
    wait_level(1'b0, 40, n, found);
    check("wd1_found", 32'(found), 32'd1);
    check("wd1_cur_ch", 32'(cur_ch), 32'd1);
    check("wd1_stu", 32'(stu_buf_rdy), 32'h02);
    n = 0;
    while (n < 200 && arm_int_n === 1'b0) begin
      if (n == 50) begin
        en_ch[1] = 1'b0;
        set_cnt(1, 4'd0);
      end
      if (n == 55) begin
        en_ch[1] = 1'b1;
        set_cnt(1, 4'd1);
      end
      @(negedge clk_sys);
      n++;
    end
    check("wd1_low_len", 32'(n), 32'd100);
    check("wd1_pulse", 32'(wd_arm_high), 32'd1);
    check("wd1_err", 32'(err_ch), 32'd0);
    @(negedge clk_sys);
    check("wd1_pulse_one_cycle", 32'(wd_arm_high), 32'd0);
    wait_level(1'b0, 40, n, found);
    check("wd2_gap", 32'(found && n >= 7 && n <= 12), 32'd1);
    check("wd2_cur_ch", 32'(cur_ch), 32'd1);
    wait_level(1'b1, 200, n, found);
    check("wd2_low_len", 32'(n), 32'd100);
    check("wd2_pulse", 32'(wd_arm_high), 32'd1);
    check("wd2_err", 32'(err_ch), 32'b0010);
    n = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_sys);
      if (arm_int_n !== 1'b1) n++;
    end
    check("fault_no_int", 32'(n), 32'd0);
    clr_err[1] = 1'b1;
    @(negedge clk_sys);
    clr_err[1] = 1'b0;
    check("clr_err", 32'(err_ch), 32'd0);
    wait_level(1'b0, 40, n, found);
    check("rearm_found", 32'(found), 32'd1);
    check("rearm_cur_ch", 32'(cur_ch), 32'd1);
    ack(1);
    set_cnt(1, 4'd0);
    wait_level(1'b1, 3, n, found);
    check("rearm_release", 32'(found), 32'd1);

    // Collision: ch2 times out once, then an acknowledge on watchdog cycle 99.
    set_cnt(2, 4'd1);
    wait_level(1'b0, 40, n, found);
    check("c1_cur_ch", 32'(cur_ch), 32'd2);
    wait_level(1'b1, 200, n, found);
    check("c1_low_len", 32'(n), 32'd100);
    check("c1_pulse", 32'(wd_arm_high), 32'd1);
    check("c1_err", 32'(err_ch), 32'd0);
    wait_level(1'b0, 40, n, found);
    check("c2_found", 32'(found), 32'd1);
    repeat (99) @(negedge clk_sys);
    check("c2_pre_collide_low", 32'(arm_int_n), 32'd0);
    buf_frm[2] = 1'b1;
    @(negedge clk_sys);
    buf_frm[2] = 1'b0;
    check("c2_release", 32'(arm_int_n), 32'd1);
    check("c2_no_pulse", 32'(wd_arm_high), 32'd0);
    @(negedge clk_sys);
    check("c2_no_pulse_late", 32'(wd_arm_high), 32'd0);
    check("c2_err", 32'(err_ch), 32'd0);
    // Retry was cleared by the acknowledge: one more timeout must not fault.
    wait_level(1'b0, 40, n, found);
    wait_level(1'b1, 200, n, found);
    check("c3_low_len", 32'(n), 32'd100);
    check("c3_err", 32'(err_ch), 32'd0);
    wait_level(1'b0, 40, n, found);
    wait_level(1'b1, 200, n, found);
    check("c4_low_len", 32'(n), 32'd100);
    check("c4_err", 32'(err_ch), 32'b0100);

    // Reset in the middle of an interrupt.
    set_cnt(0, 4'd1);
    wait_level(1'b0, 40, n, found);
    check("mr_found", 32'(found), 32'd1);
    check("mr_cur_ch", 32'(cur_ch), 32'd0);
    repeat (5) @(negedge clk_sys);
    rst_n = 1'b0;
    #1;
    check("mr_arm_async", 32'(arm_int_n), 32'd1);
    check("mr_err", 32'(err_ch), 32'd0);
    check("mr_stu", 32'(stu_buf_rdy), 32'h00);
    @(negedge clk_sys);
    rst_n = 1'b1;
    wait_level(1'b0, 40, n, found);
    check("mr_holdoff_window", 32'(found && n >= 17 && n <= 19), 32'd1);
    check("mr_cur_ch_after", 32'(cur_ch), 32'd0);
    check("mr_stu_after", 32'(stu_buf_rdy), 32'h01);
    ack(0);
    cnt_pkg_buf = '0;
    wait_level(1'b1, 3, n, found);
    check("mr_release", 32'(found), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
